// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: FSM state encoding and
// the legal oversampling ratios.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } rx_state_e;

  localparam logic [5:0] PrescaleX8  = 6'd8;
  localparam logic [5:0] PrescaleX16 = 6'd16;
  localparam logic [5:0] PrescaleX32 = 6'd32;

  // Any ratio other than 16 or 32 falls back to 8.
  function automatic logic [5:0] eff_prescale(input logic [5:0] raw);
    case (raw)
      PrescaleX16: return PrescaleX16;
      PrescaleX32: return PrescaleX32;
      default:     return PrescaleX8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and bit counter; the bit counter advances each
// time the edge counter wraps from edge_max_i back to zero.
module uart_rx_edge_bit_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [5:0] edge_max_i,
  output logic [5:0] edge_cnt_o,
  output logic [3:0] bit_cnt_o
);

  logic [5:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;

  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clr_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (en_i) begin
      if (edge_q == edge_max_i) begin
        edge_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: sequences start/data/parity/stop bits, drives
// the datapath sample/check enables and reports frame completion.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic       par_en,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       new_frame,
  output logic       data_valid,
  output logic       frame_err
);

  rx_state_e  state_q, state_d;
  logic [5:0] p_q, p_d;
  logic       par_en_q, par_en_d;
  logic       new_frame_q, new_frame_d;
  logic       data_valid_q, data_valid_d;
  logic       frame_err_q, frame_err_d;

  logic       active_q, active_d, cnt_run, last_edge;
  logic [5:0] half;

  assign active_q  = state_q inside {StStart, StData, StParity, StStop};
  assign active_d  = state_d inside {StStart, StData, StParity, StStop};
  // Counters only run while staying inside a frame; any entry/exit clears them.
  assign cnt_run   = active_q && active_d;
  assign last_edge = (edge_cnt == p_q - 6'd1);
  assign half      = p_q >> 1;

  uart_rx_edge_bit_counter u_counter (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (!cnt_run),
    .en_i       (cnt_run),
    .edge_max_i (p_q - 6'd1),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt)
  );

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    par_en_d     = par_en_q;
    new_frame_d  = 1'b0;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (!rx_in) begin
          state_d     = StStart;
          p_d         = eff_prescale(prescale);
          par_en_d    = par_en;
          new_frame_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: if (last_edge) state_d = strt_glitch ? StIdle : StData;
      StData: begin
        if (last_edge && bit_cnt == 4'(DATA_WIDTH)) state_d = par_en_q ? StParity : StStop;
      end
      StParity: if (last_edge) state_d = StStop;
      StStop: begin
        if (last_edge) begin
          state_d = StDone;
          if (stp_err || (par_en_q && par_err)) frame_err_d = 1'b1;
          else data_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      p_q          <= PrescaleX8;
      par_en_q     <= 1'b0;
      new_frame_q  <= 1'b0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      par_en_q     <= par_en_d;
      new_frame_q  <= new_frame_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  logic chk_pt;
  assign chk_pt = active_q && (edge_cnt == half + 6'd2);

  assign dat_samp_en = active_q && (edge_cnt >= half - 6'd1) && (edge_cnt <= half + 6'd1);
  assign strt_chk_en = chk_pt && (state_q == StStart);
  assign deser_en    = chk_pt && (state_q == StData);
  assign par_chk_en  = chk_pt && (state_q == StParity);
  assign stp_chk_en  = chk_pt && (state_q == StStop);
  assign new_frame   = new_frame_q;
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frame table, reset-abort sequence and
// randomized frames checked cycle by cycle against a frame-timing model.
module tb_uart_rx_ctrl;

  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en, strt_glitch, par_err, stp_err;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       new_frame, data_valid, frame_err;

  int total = 0;
  int bad   = 0;

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .new_frame   (new_frame),
    .data_valid  (data_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] got_vec();
    return {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
            new_frame, data_valid, frame_err, edge_cnt, bit_cnt};
  endfunction

  function automatic int eff_p(input int raw);
    if (raw == 16) return 16;
    if (raw == 32) return 32;
    return 8;
  endfunction

  // Expected outputs in cycle c of a run of n frames (cycle 1 = first START cycle).
  function automatic logic [17:0] exp_vec(input int c, input int p, input int par, input int gl,
                                          input int n, input int perr, input int serr);
    int len, per, lc, e, b, h;
    logic samp, sc, dc, pc, stc, nf, dv, fe;
    len = gl != 0 ? p : p * (DW + 2 + par);
    per = len + 1;
    {samp, sc, dc, pc, stc, nf, dv, fe} = '0;
    e = 0;
    b = 0;
    if (c >= 1 && c <= n * per) begin
      lc = (c - 1) % per + 1;
      if (lc == per) begin
        if (gl == 0) begin
          dv = !(serr != 0 || (par != 0 && perr != 0));
          fe = !dv;
        end
      end else begin
        e    = (lc - 1) % p;
        b    = (lc - 1) / p;
        h    = p / 2;
        nf   = (lc == 1);
        samp = (e >= h - 1) && (e <= h + 1);
        if (e == h + 2) begin
          if (b == 0) sc = 1'b1;
          else if (b <= DW) dc = 1'b1;
          else if (par != 0 && b == DW + 1) pc = 1'b1;
          else stc = 1'b1;
        end
      end
    end
    return {samp, dc, sc, pc, stc, nf, dv, fe, 6'(e), 4'(b)};
  endfunction

  task automatic check(input string name, input int cyc, input logic [17:0] got,
                       input logic [17:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Runs n frames (back-to-back when n>1) and scrambles prescale/par_en mid-frame.
  task automatic run_case(input string name, input int p_raw, input int par, input int perr,
                          input int serr, input int gl, input int n, output int ev1,
                          output int evl, output int ndv, output int nfe, output int ndes);
    int p, len, per, lc, f;
    p   = eff_p(p_raw);
    len = gl != 0 ? p : p * (DW + 2 + par);
    per = len + 1;
    ev1 = 0; evl = 0; ndv = 0; nfe = 0; ndes = 0;
    prescale    = 6'(p_raw);
    par_en      = 1'(par);
    par_err     = 1'(perr);
    stp_err     = 1'(serr);
    strt_glitch = 1'(gl);
    @(negedge clk);
    rx_in = 1'b0;
    for (int c = 1; c <= n * per + 2; c++) begin
      @(posedge clk);
      #1;
      lc = (c - 1) % per + 1;
      f  = (c - 1) / per;
      rx_in = 1'b1;
      if (c <= n * per && (lc == 1 || (lc == per && f < n - 1))) rx_in = 1'b0;
      if (c <= n * per && lc >= 2 && lc <= len) begin
        prescale = 6'($urandom_range(0, 63));
        par_en   = 1'($urandom_range(0, 1));
      end else begin
        prescale = 6'(p_raw);
        par_en   = 1'(par);
      end
      @(negedge clk);
      check(name, c, got_vec(), exp_vec(c, p, par, gl, n, perr, serr));
      if (data_valid || frame_err) begin
        if (ev1 == 0) ev1 = c;
        evl = c;
      end
      if (data_valid) ndv++;
      if (frame_err) nfe++;
      if (deser_en) ndes++;
    end
  endtask

  typedef struct {
    string name;
    int p_raw, par, perr, serr, gl, n;
    int ev1, evl, ndv, nfe, ndes;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int ev1, evl, ndv, nfe, ndes;
    tbl[0] = '{"p8_par_a5",    8, 1, 0, 0, 0, 1,  89,  89, 1, 0,  8};
    tbl[1] = '{"p16_nopar",   16, 0, 0, 0, 0, 1, 161, 161, 1, 0,  8};
    tbl[2] = '{"p8_glitch",    8, 1, 0, 0, 1, 1,   0,   0, 0, 0,  0};
    tbl[3] = '{"p8_par_err",   8, 1, 1, 0, 0, 1,  89,  89, 0, 1,  8};
    tbl[4] = '{"p8_stp_err",   8, 1, 0, 1, 0, 1,  89,  89, 0, 1,  8};
    tbl[5] = '{"p8_perr_ign",  8, 0, 1, 0, 0, 1,  81,  81, 1, 0,  8};
    tbl[6] = '{"p8_b2b",       8, 1, 0, 0, 0, 2,  89, 178, 2, 0, 16};
    tbl[7] = '{"p32_par",     32, 1, 0, 0, 0, 1, 353, 353, 1, 0,  8};
    tbl[8] = '{"p12_as_8",    12, 0, 0, 0, 0, 1,  81,  81, 1, 0,  8};
    tbl[9] = '{"p0_as_8",      0, 1, 0, 0, 0, 1,  89,  89, 1, 0,  8};

    rst = 1'b1; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    #1;
    check("reset_state", 0, got_vec(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", 0, got_vec(), '0);

    foreach (tbl[i]) begin
      run_case(tbl[i].name, tbl[i].p_raw, tbl[i].par, tbl[i].perr, tbl[i].serr, tbl[i].gl,
               tbl[i].n, ev1, evl, ndv, nfe, ndes);
      check_int({tbl[i].name, "_first_event"}, ev1, tbl[i].ev1);
      check_int({tbl[i].name, "_last_event"}, evl, tbl[i].evl);
      check_int({tbl[i].name, "_dv_count"}, ndv, tbl[i].ndv);
      check_int({tbl[i].name, "_fe_count"}, nfe, tbl[i].nfe);
      check_int({tbl[i].name, "_deser_count"}, ndes, tbl[i].ndes);
    end

    // Reset asserted during data bit 4 aborts the frame asynchronously.
    prescale = 6'd8; par_en = 1'b1; par_err = 1'b0; stp_err = 1'b0; strt_glitch = 1'b0;
    @(negedge clk);
    rx_in = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      @(posedge clk);
      #1;
      rx_in = (c == 1) ? 1'b0 : 1'b1;
      @(negedge clk);
      check("pre_abort", c, got_vec(), exp_vec(c, 8, 1, 0, 1, 0, 0));
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_abort", 35, got_vec(), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("idle_after_abort", c, got_vec(), '0);
    end
    run_case("after_abort", 8, 1, 0, 0, 0, 1, ev1, evl, ndv, nfe, ndes);
    check_int("after_abort_dv_cycle", ev1, 89);
    check_int("after_abort_dv_count", ndv, 1);

    for (int k = 0; k < 8; k++) begin
      int pr, par, gl, perr, serr, n;
      case ($urandom_range(0, 3))
        0: pr = 8;
        1: pr = 16;
        2: pr = 32;
        default: pr = int'($urandom_range(0, 63));
      endcase
      par  = int'($urandom_range(0, 1));
      gl   = ($urandom_range(0, 3) == 0) ? 1 : 0;
      perr = ($urandom_range(0, 3) == 0) ? 1 : 0;
      serr = ($urandom_range(0, 3) == 0) ? 1 : 0;
      n    = gl != 0 ? 1 : int'($urandom_range(1, 2));
      run_case("random", pr, par, perr, serr, gl, n, ev1, evl, ndv, nfe, ndes);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
